// File: rtl/mips16_ctrl_pkg.sv
// Shared definitions for the multicycle 16-bit MIPS control path: opcodes,
// ALU-op codes, datapath mux selects and the sequencer state encoding.
package mips16_ctrl_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_SLTI  = 4'b0010;
  localparam logic [3:0] OP_LW    = 4'b0011;
  localparam logic [3:0] OP_SW    = 4'b0100;
  localparam logic [3:0] OP_BEQ   = 4'b0101;
  localparam logic [3:0] OP_J     = 4'b0110;

  localparam logic [3:0] FN_MUL = 4'b0101;

  localparam logic [1:0] ALUOP_FUNCT = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_SLT   = 2'b10;
  localparam logic [1:0] ALUOP_ADD   = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic       SRCA_PC   = 1'b0;
  localparam logic       SRCA_REGA = 1'b1;
  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic IORD_PC     = 1'b0;
  localparam logic IORD_ALUOUT = 1'b1;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_MEM_WB,
    S_WB_R,
    S_WB_I,
    S_BRANCH,
    S_JUMP
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= OP_J);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the sequencer (master) and the datapath (slave):
// instruction fields and memory handshake in, mux selects and enables out.
interface multicycle_ctrl_fsm_if;
  logic [3:0] opcode;
  logic [3:0] funct;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       i_or_d;
  logic       ir_write;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       illegal_op;

  modport master (
    input  opcode, funct, mem_ready,
    output mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal_op
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal_op
  );
endinterface

// File: rtl/multicycle_ctrl_fsm_mul_stall_counter.sv
// Loadable down-counter that holds the sequencer in EXEC_R while a multiply
// completes; saturates at zero.
module mul_stall_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS16 control sequencer: fetch/decode/execute/memory/write-back
// with memory-ready stalls and a configurable multi-cycle multiply.
module multicycle_ctrl_fsm
  import mips16_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  multicycle_ctrl_fsm_if.master       bus
);

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  state_t     state_reg;
  ctrl_t      ctrl;
  logic       cnt_zero;
  logic [3:0] cnt_value;
  logic       is_mul;

  assign is_mul = (bus.funct == FN_MUL);

  // Counter is reloaded on every entry to EXEC_R; only mul consults it.
  mul_stall_counter #(.WIDTH(4)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     ((state_reg == S_DECODE) && (bus.opcode == OP_RTYPE)),
    .load_val (MUL_LOAD),
    .dec      (state_reg == S_EXEC_R),
    .count    (cnt_value),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
    end else begin
      case (state_reg)
        S_FETCH:    if (bus.mem_ready) state_reg <= S_DECODE;
        S_DECODE: begin
          case (bus.opcode)
            OP_RTYPE:        state_reg <= S_EXEC_R;
            OP_ADDI, OP_SLTI: state_reg <= S_EXEC_I;
            OP_LW, OP_SW:    state_reg <= S_MEM_ADDR;
            OP_BEQ:          state_reg <= S_BRANCH;
            OP_J:            state_reg <= S_JUMP;
            default:         state_reg <= S_FETCH;
          endcase
        end
        S_EXEC_R:   if (!is_mul || cnt_zero) state_reg <= S_WB_R;
        S_EXEC_I:   state_reg <= S_WB_I;
        S_MEM_ADDR: state_reg <= (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (bus.mem_ready) state_reg <= S_MEM_WB;
        S_MEM_WR:   if (bus.mem_ready) state_reg <= S_FETCH;
        default:    state_reg <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    ctrl = '0;
    case (state_reg)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.i_or_d    = IORD_PC;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_ONE;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.ir_write  = bus.mem_ready;
        ctrl.pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = !is_legal_op(bus.opcode);
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = SRCA_REGA;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = SRCA_REGA;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = (bus.opcode == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = SRCA_REGA;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_req = 1'b1;
        ctrl.i_or_d  = IORD_ALUOUT;
      end
      S_MEM_WR: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.i_or_d  = IORD_ALUOUT;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_WB_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_WB_I:   ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a     = SRCA_REGA;
        ctrl.alu_src_b     = SRCB_REGB;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
      end
      default: ;
    endcase
    // Reset silences every enable so an abandoned instruction cannot commit.
    if (rst) ctrl = '0;
  end

  assign bus.mem_req       = ctrl.mem_req;
  assign bus.mem_we        = ctrl.mem_we;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.pc_src        = ctrl.pc_src;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.illegal_op    = ctrl.illegal_op;

  logic unused_ok;
  assign unused_ok = ^cnt_value;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Cycle-by-cycle bench for multicycle_ctrl_fsm: planned per-cycle stimulus,
// expected control vectors queued at drive time and compared at the negedge.
module tb_multicycle_ctrl_fsm;
  import mips16_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;   // 0: observe MUL_CYCLES=4 instance, 1: MUL_CYCLES=1
  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if if4 ();
  multicycle_ctrl_fsm_if if1 ();

  multicycle_ctrl_fsm #(.MUL_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  multicycle_ctrl_fsm #(.MUL_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  logic [16:0] v4, v1;
  assign v4 = {if4.mem_req, if4.mem_we, if4.i_or_d, if4.ir_write, if4.pc_write, if4.pc_write_cond,
               if4.pc_src, if4.alu_src_a, if4.alu_src_b, if4.alu_op,
               if4.reg_write, if4.reg_dst, if4.mem_to_reg, if4.illegal_op};
  assign v1 = {if1.mem_req, if1.mem_we, if1.i_or_d, if1.ir_write, if1.pc_write, if1.pc_write_cond,
               if1.pc_src, if1.alu_src_a, if1.alu_src_b, if1.alu_op,
               if1.reg_write, if1.reg_dst, if1.mem_to_reg, if1.illegal_op};

  logic [3:0]  op_q[$];
  logic [3:0]  fn_q[$];
  state_t      st_q[$];
  logic        mr_q[$];
  logic        rs_q[$];
  logic [16:0] sb_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Expected control vector for a state, straight from the per-state action table.
  function automatic logic [16:0] exp_vec(input state_t s, input logic mr, input logic [3:0] op);
    logic req, we, iord, irw, pcw, pcwc, sa, rw, rd, m2r, ill;
    logic [1:0] ps, sb, ao;
    {req, we, iord, irw, pcw, pcwc, sa, rw, rd, m2r, ill} = '0;
    ps = 2'b00; sb = 2'b00; ao = 2'b00;
    case (s)
      S_FETCH:    begin req = 1; sb = 2'b01; ao = 2'b11; irw = mr; pcw = mr; end
      S_DECODE:   begin sb = 2'b10; ao = 2'b11; ill = (op >= 4'd7); end
      S_EXEC_R:   begin sa = 1; end
      S_EXEC_I:   begin sa = 1; sb = 2'b10; ao = (op == 4'd2) ? 2'b10 : 2'b11; end
      S_MEM_ADDR: begin sa = 1; sb = 2'b10; ao = 2'b11; end
      S_MEM_RD:   begin req = 1; iord = 1; end
      S_MEM_WR:   begin req = 1; we = 1; iord = 1; end
      S_MEM_WB:   begin rw = 1; m2r = 1; end
      S_WB_R:     begin rw = 1; rd = 1; end
      S_WB_I:     begin rw = 1; end
      S_BRANCH:   begin sa = 1; ao = 2'b01; pcwc = 1; ps = 2'b01; end
      S_JUMP:     begin pcw = 1; ps = 2'b10; end
      default: ;
    endcase
    return {req, we, iord, irw, pcw, pcwc, ps, sa, sb, ao, rw, rd, m2r, ill};
  endfunction

  task automatic plan(input logic [3:0] op, input logic [3:0] fn, input state_t s,
                      input logic mr, input logic r);
    op_q.push_back(op); fn_q.push_back(fn); st_q.push_back(s);
    mr_q.push_back(mr); rs_q.push_back(r);
  endtask

  // Expected state walk of one instruction, with fetch and memory wait cycles.
  task automatic plan_inst(input logic [3:0] op, input logic [3:0] fn, input int fw, input int mw);
    repeat (fw) plan(op, fn, S_FETCH, 1'b0, 1'b0);
    plan(op, fn, S_FETCH, 1'b1, 1'b0);
    plan(op, fn, S_DECODE, 1'b1, 1'b0);
    case (op)
      OP_RTYPE: begin
        repeat ((fn == FN_MUL) ? (sel ? 1 : 4) : 1) plan(op, fn, S_EXEC_R, 1'b1, 1'b0);
        plan(op, fn, S_WB_R, 1'b1, 1'b0);
      end
      OP_ADDI, OP_SLTI: begin
        plan(op, fn, S_EXEC_I, 1'b1, 1'b0);
        plan(op, fn, S_WB_I, 1'b1, 1'b0);
      end
      OP_LW: begin
        plan(op, fn, S_MEM_ADDR, 1'b1, 1'b0);
        repeat (mw) plan(op, fn, S_MEM_RD, 1'b0, 1'b0);
        plan(op, fn, S_MEM_RD, 1'b1, 1'b0);
        plan(op, fn, S_MEM_WB, 1'b1, 1'b0);
      end
      OP_SW: begin
        plan(op, fn, S_MEM_ADDR, 1'b1, 1'b0);
        repeat (mw) plan(op, fn, S_MEM_WR, 1'b0, 1'b0);
        plan(op, fn, S_MEM_WR, 1'b1, 1'b0);
      end
      OP_BEQ:  plan(op, fn, S_BRANCH, 1'b1, 1'b0);
      OP_J:    plan(op, fn, S_JUMP, 1'b1, 1'b0);
      default: ;
    endcase
  endtask

  // Applies the next planned cycle and queues what the outputs must show.
  task automatic drive(output state_t s);
    logic [3:0] op, fn;
    logic mr, r;
    op = op_q.pop_front(); fn = fn_q.pop_front(); s = st_q.pop_front();
    mr = mr_q.pop_front(); r = rs_q.pop_front();
    if4.opcode = op; if1.opcode = op;
    if4.funct = fn;  if1.funct = fn;
    if4.mem_ready = mr; if1.mem_ready = mr;
    rst = r;
    sb_q.push_back(r ? 17'd0 : exp_vec(s, mr, op));
  endtask

  task automatic test_reset();
    state_t s; logic [16:0] got, want;
    plan(4'd0, 4'd0, S_FETCH, 1'b1, 1'b1);
    plan(4'd0, 4'd0, S_FETCH, 1'b1, 1'b1);
    plan_inst(OP_RTYPE, 4'd0, 0, 0);
    plan(4'd0, 4'd0, S_FETCH, 1'b0, 1'b0);
    while (st_q.size() != 0) begin
      drive(s); @(negedge clk);
      got = sel ? v1 : v4; want = sb_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL reset_rtype %s got=%h want=%h", s.name(), got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_wait();
    state_t s; logic [16:0] got, want;
    plan_inst(OP_LW, 4'd0, 0, 3);
    while (st_q.size() != 0) begin
      drive(s); @(negedge clk);
      got = sel ? v1 : v4; want = sb_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL lw_wait %s got=%h want=%h", s.name(), got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_imm();
    state_t s; logic [16:0] got, want;
    plan_inst(OP_SW, 4'd0, 2, 1);
    plan_inst(OP_ADDI, 4'd3, 0, 0);
    plan_inst(OP_SLTI, 4'd9, 1, 0);
    while (st_q.size() != 0) begin
      drive(s); @(negedge clk);
      got = sel ? v1 : v4; want = sb_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL sw_imm %s got=%h want=%h", s.name(), got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mul();
    state_t s; logic [16:0] got, want;
    plan_inst(OP_RTYPE, FN_MUL, 0, 0);
    while (st_q.size() != 0) begin
      drive(s); @(negedge clk);
      got = sel ? v1 : v4; want = sb_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL mul4 %s got=%h want=%h", s.name(), got, want);
      end
      @(posedge clk); #1;
    end
    sel = 1'b1;
    plan(4'd0, 4'd0, S_FETCH, 1'b1, 1'b1);
    plan_inst(OP_RTYPE, FN_MUL, 0, 0);
    plan(4'd0, 4'd0, S_FETCH, 1'b1, 1'b1);
    while (st_q.size() != 0) begin
      drive(s); @(negedge clk);
      got = sel ? v1 : v4; want = sb_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL mul1 %s got=%h want=%h", s.name(), got, want);
      end
      @(posedge clk); #1;
    end
    sel = 1'b0;
  endtask

  task automatic test_branch_jump();
    state_t s; logic [16:0] got, want;
    plan_inst(OP_BEQ, 4'd0, 0, 0);
    plan_inst(OP_J, 4'd0, 0, 0);
    while (st_q.size() != 0) begin
      drive(s); @(negedge clk);
      got = sel ? v1 : v4; want = sb_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL branch_jump %s got=%h want=%h", s.name(), got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    state_t s; logic [16:0] got, want;
    plan_inst(4'b1010, 4'd0, 0, 0);
    plan(4'b1010, 4'd0, S_FETCH, 1'b0, 1'b0);
    plan_inst(4'b0111, 4'd0, 0, 0);
    plan_inst(OP_ADDI, 4'd0, 0, 0);
    while (st_q.size() != 0) begin
      drive(s); @(negedge clk);
      got = sel ? v1 : v4; want = sb_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL illegal %s got=%h want=%h", s.name(), got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_mul();
    state_t s; logic [16:0] got, want;
    plan(4'd0, FN_MUL, S_FETCH, 1'b1, 1'b0);
    plan(4'd0, FN_MUL, S_DECODE, 1'b1, 1'b0);
    plan(4'd0, FN_MUL, S_EXEC_R, 1'b1, 1'b0);
    plan(4'd0, FN_MUL, S_EXEC_R, 1'b1, 1'b1);
    while (st_q.size() != 0) begin
      drive(s); @(negedge clk);
      got = sel ? v1 : v4; want = sb_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL reset_mid_mul %s got=%h want=%h", s.name(), got, want);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (dut4.u_cnt.count !== 4'd0) begin
      n_err++; $display("FAIL reset_mid_mul counter got=%0d want=0", dut4.u_cnt.count);
    end
    plan_inst(OP_RTYPE, FN_MUL, 1, 0);
    while (st_q.size() != 0) begin
      drive(s); @(negedge clk);
      got = sel ? v1 : v4; want = sb_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL after_reset_mul %s got=%h want=%h", s.name(), got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    state_t s; logic [16:0] got, want;
    logic [3:0] op, fn;
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 6));
      fn = ($urandom_range(0, 1) == 0) ? FN_MUL : 4'($urandom_range(0, 15));
      plan_inst(op, fn, $urandom_range(0, 2), $urandom_range(0, 3));
    end
    while (st_q.size() != 0) begin
      drive(s); @(negedge clk);
      got = sel ? v1 : v4; want = sb_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL back_to_back %s got=%h want=%h", s.name(), got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    if4.opcode = 4'd0; if1.opcode = 4'd0;
    if4.funct = 4'd0;  if1.funct = 4'd0;
    if4.mem_ready = 1'b0; if1.mem_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_lw_wait();
    test_sw_imm();
    test_mul();
    test_branch_jump();
    test_illegal();
    test_reset_mid_mul();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Main control sequencer for the multicycle 16-bit MIPS datapath. It walks each instruction through fetch, decode, execute, memory and write-back. On every cycle it drives the datapath mux selects, the write enables and the 2-bit `alu_op` that feeds the ALU control unit. It also stalls on a request/ready memory handshake, and holds the execute state for a configurable number of cycles on `mul`.

## Interface
- `MUL_CYCLES`, default 4: cycles spent in EXEC_R for funct 4'b0101 (mul); legal range 1..15.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `opcode` input 4: instruction register bits [15:12].
- `funct` input 4: instruction register bits [3:0].
- `mem_ready` input 1: memory completed the current request this cycle.
- `mem_req` output 1: memory access request.
- `mem_we` output 1: memory write (valid with `mem_req`).
- `i_or_d` output 1: memory address mux; 0 = PC, 1 = ALUOut.
- `ir_write` output 1: load the instruction register.
- `pc_write` output 1: unconditional PC load.
- `pc_write_cond` output 1: PC load if ALU zero.
- `pc_src` output 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_src_a` output 1: 0 = PC, 1 = register A.
- `alu_src_b` output 2: 00 = register B, 01 = constant 1, 10 = sign-extended immediate.
- `alu_op` output 2: 00 = use funct, 01 = sub, 10 = slt, 11 = add.
- `reg_write` output 1: register file write enable.
- `reg_dst` output 1: 0 = rt, 1 = rd.
- `mem_to_reg` output 1: 0 = ALUOut, 1 = MDR.
- `illegal_op` output 1: one-cycle pulse on an undefined opcode.

## Operation
- Opcode map:
  - 0000 R-type
  - 0001 addi
  - 0010 slti
  - 0011 lw
  - 0100 sw
  - 0101 beq
  - 0110 j
  - 0111–1111 illegal.
- Registered state, Moore outputs decoded from state. Exceptions: `ir_write` and `pc_write` in FETCH, plus the counter exit, also depend on `mem_ready`.
- All outputs not listed for a state are 0.
- States and per-state actions:
  - **FETCH**: `mem_req`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=11, `pc_src`=00. When `mem_ready`=1: `ir_write`=1, `pc_write`=1, next state DECODE. Otherwise stay.
  - **DECODE**: `alu_src_a`=0, `alu_src_b`=10, `alu_op`=11 (branch target precompute). Next state by opcode:
    - R → EXEC_R
    - addi/slti → EXEC_I
    - lw/sw → MEM_ADDR
    - beq → BRANCH
    - j → JUMP
    - illegal → FETCH with `illegal_op`=1.
  - **EXEC_R**: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=00.
    - funct ≠ 0101: one cycle, then WB_R.
    - funct = 0101: down-counter loaded with MUL_CYCLES-1 on entry; stay until the counter reads 0, then WB_R.
  - **EXEC_I**: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=11 (addi) or 10 (slti). Next state WB_I.
  - **MEM_ADDR**: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=11. Next state MEM_RD (lw) or MEM_WR (sw).
  - **MEM_RD**: `mem_req`=1, `i_or_d`=1. Stay until `mem_ready`, then MEM_WB.
  - **MEM_WR**: `mem_req`=1, `mem_we`=1, `i_or_d`=1. Stay until `mem_ready`, then FETCH.
  - **MEM_WB**: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Next state FETCH.
  - **WB_R**: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Next state FETCH.
  - **WB_I**: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Next state FETCH.
  - **BRANCH**: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_src`=01. Next state FETCH.
  - **JUMP**: `pc_write`=1, `pc_src`=10. Next state FETCH.
- `opcode` and `funct` are sampled every cycle; they are stable from DECODE until the next FETCH because the IR holds them.

## Timing
- Reset:
  - `rst` high at a rising edge → state FETCH, mul counter 0.
  - While `rst` is high, every output is forced to 0, including `mem_req`.
  - Reset mid-instruction or mid-mul abandons it with no write enable asserted in the reset cycle.
- Instruction latency with zero memory wait:
  - R (non-mul): 4 cycles
  - mul: 3+MUL_CYCLES cycles
  - addi/slti: 4
  - lw: 5
  - sw: 4
  - beq: 3
  - j: 3.
- Each cycle `mem_ready` stays low adds exactly one cycle in FETCH, MEM_RD or MEM_WR.
- `mem_req` stays high and its address/we stay stable until the `mem_ready` cycle.
- `mem_ready` outside a requesting state is ignored.
- With MUL_CYCLES=1, mul behaves like a single-cycle R op.

## Structure
- Shared package `mips16_ctrl_pkg` holds:
  - opcode constants (OP_RTYPE … OP_J)
  - funct constant FN_MUL
  - ALUOP_FUNCT/SUB/SLT/ADD
  - mux select constants
  - the state enum, which the ALU control unit and datapath also import.
- One sub-module: `mul_stall_counter` (load, decrement, `zero` flag, 4-bit).
- The FSM stays a single always block for next state plus a combinational output decode.

## Test plan
- `rst` high 2 cycles, then `opcode`=0000, `funct`=0000, `mem_ready`=1 → all outputs 0 during reset; FETCH→DECODE→EXEC_R→WB_R with `alu_op`=00 in EXEC_R and `reg_write`=`reg_dst`=1 in cycle 4.
- lw with `mem_ready` low 3 cycles in MEM_RD → `mem_req`=1, `i_or_d`=1 held 4 cycles; `reg_write`=`mem_to_reg`=1 exactly one cycle later; total 8 cycles.
- mul (`funct`=0101), MUL_CYCLES=4 → EXEC_R lasts exactly 4 cycles with `alu_op`=00, then WB_R; repeat with MUL_CYCLES=1 and see EXEC_R last 1 cycle.
- beq then j → BRANCH shows `alu_op`=01, `pc_write_cond`=1, `pc_src`=01; JUMP shows `pc_write`=1, `pc_src`=10; each instruction takes 3 cycles.
- `opcode`=1010 → `illegal_op` pulses 1 cycle in DECODE, next state FETCH, no `reg_write`/`mem_we`.
- `rst` asserted in the 2nd EXEC_R cycle of mul → next cycle FETCH, counter 0, `reg_write` never asserted for that instruction.
